instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/instr_fetch_queue.sv | 111 +++++++++++
 tb/tb_instr_fetch_queue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: widths, fetch FSM states, queue entry.
package fetch_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instruction;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instruction} entries with clear.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  fetch_entry_t                 push_data_i,
  input  logic                         pop_i,
  output fetch_entry_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  fetch_entry_t     mem_q [DEPTH];

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PTR_W'(1);
      if (pop_i)  rptr_q <= rptr_q + PTR_W'(1);
      if (push_i && !pop_i)      count_q <= count_q + CNT_W'(1);
      else if (!push_i && pop_i) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !clear_i) begin
      assert (!(push_i && full && !pop_i));
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch engine with one outstanding imem request and a credit-gated fetch queue.
// Define FETCHQ_BYPASS_EN to forward a response straight to the output when the queue is empty.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [INSTR_W-1:0]         imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [INSTR_W-1:0]         out_instruction,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] tag_pc_q, tag_pc_d;

  fetch_entry_t    push_entry, fifo_head;
  logic [CNT_W-1:0] fifo_count, count_after_pop;
  logic            fifo_empty, fifo_push, fifo_pop;
  logic            rsp_keep, bypass, head_valid;

  assign push_entry = '{pc: tag_pc_q, instruction: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .clear_i     (redirect_valid),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign rsp_keep = (state_q == ST_WAIT) && imem_rvalid && !redirect_valid;

`ifdef FETCHQ_BYPASS_EN
  assign bypass = rsp_keep && fifo_empty && out_ready && !reset;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push  = rsp_keep && !bypass;
  assign head_valid = !fifo_empty && !redirect_valid && !reset;
  assign fifo_pop   = head_valid && out_ready;

  assign out_valid       = head_valid || bypass;
  assign out_pc          = bypass ? tag_pc_q   : fifo_head.pc;
  assign out_instruction = bypass ? imem_rdata : fifo_head.instruction;
  assign count           = fifo_count;

  // A request needs a free slot for its response, counting a pop in this cycle
  assign count_after_pop = fifo_count - CNT_W'(fifo_pop);
  assign imem_req  = !reset && (state_q == ST_IDLE) && !redirect_valid &&
                     (count_after_pop < CNT_W'(DEPTH));
  assign imem_addr = fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    tag_pc_d   = tag_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (imem_req && imem_gnt) begin
          state_d    = ST_WAIT;
          tag_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 64'd4;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid)         state_d = ST_IDLE;
        else if (redirect_valid) state_d = ST_DROP;
      end
      ST_DROP: begin
        if (imem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (redirect_valid) fetch_pc_d = word_align(redirect_pc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= word_align(RESET_PC);
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_pc_q <= tag_pc_d;
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (DEPTH=4, RESET_PC=0); adapts to FETCHQ_BYPASS_EN.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instruction;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] mon_pc [$];
  logic [31:0] mon_ins [$];

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instruction (out_instruction),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .count           (count)
  );

  always #5 clk = ~clk;

  // Records every accepted output transfer, mid-cycle
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      mon_pc.push_back(out_pc);
      mon_ins.push_back(out_instruction);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] word_for(input logic [63:0] pc);
    return 32'hA000_0000 | pc[31:0];
  endfunction

  initial begin
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    chk("rst_req", imem_req, 0);
    chk("rst_oval", out_valid, 0);
    chk("rst_count", count, 0);

    // Sequential fetch with an always-ready consumer
    reset = 1'b0; imem_gnt = 1'b1; out_ready = 1'b1;
    mon_pc.delete(); mon_ins.delete();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("seq_req", imem_req, 1);
      chk("seq_addr", imem_addr, 64'(i * 4));
      tick();
      imem_rvalid = 1'b1; imem_rdata = word_for(64'(i * 4));
      tick();
      imem_rvalid = 1'b0;
    end
    imem_gnt = 1'b0;
    tick();
    chk("seq_npop", mon_pc.size(), 3);
    for (int i = 0; i < 3 && i < mon_pc.size(); i++) begin
      chk("seq_pc", mon_pc[i], 64'(i * 4));
      chk("seq_ins", mon_ins[i], word_for(64'(i * 4)));
    end
    chk("seq_count", count, 0);

    // Fill the queue with the consumer stalled
    out_ready = 1'b0; imem_gnt = 1'b1;
    mon_pc.delete(); mon_ins.delete();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("fill_req", imem_req, 1);
      chk("fill_addr", imem_addr, 64'h0C + 64'(i * 4));
      tick();
      imem_rvalid = 1'b1; imem_rdata = word_for(64'h0C + 64'(i * 4));
      tick();
      imem_rvalid = 1'b0;
    end
    settle();
    chk("full_count", count, 4);
    chk("full_req", imem_req, 0);
    tick();
    chk("full_req2", imem_req, 0);
    out_ready = 1'b1;
    settle();
    chk("pop_req", imem_req, 1);
    chk("pop_addr", imem_addr, 64'h1C);
    chk("pop_pc", out_pc, 64'h0C);
    tick();
    imem_gnt = 1'b0; out_ready = 1'b0;
    settle();
    chk("wait_req", imem_req, 0);
    chk("wait_count", count, 3);

    // Simultaneous push and pop across pointer wrap
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; out_ready = 1'b1;
    settle();
    chk("pp_head", out_pc, 64'h10);
    tick();
    imem_rvalid = 1'b0;
    chk("pp_count", count, 3);
    tick(); tick(); tick();
    chk("drain_count", count, 0);
    chk("order_n", mon_pc.size(), 5);
    for (int i = 0; i < 5 && i < mon_pc.size(); i++) begin
      chk("order_pc", mon_pc[i], 64'h0C + 64'(i * 4));
      chk("order_ins", mon_ins[i], (i == 4) ? 32'h0000_0013 : word_for(64'h0C + 64'(i * 4)));
    end

    // Redirect while waiting, with one entry queued
    out_ready = 1'b0; imem_gnt = 1'b1;
    mon_pc.delete(); mon_ins.delete();
    settle();
    chk("rd_addr0", imem_addr, 64'h20);
    tick();
    imem_rvalid = 1'b1; imem_rdata = word_for(64'h20);
    tick();
    imem_rvalid = 1'b0;
    settle();
    chk("rd_addr1", imem_addr, 64'h24);
    tick();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h1002; out_ready = 1'b1;
    settle();
    chk("rd_oval", out_valid, 0);
    chk("rd_req", imem_req, 0);
    tick();
    redirect_valid = 1'b0;
    chk("rd_count", count, 0);
    chk("drop_req", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("drop_oval", out_valid, 0);
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    settle();
    chk("rd_newreq", imem_req, 1);
    chk("rd_newaddr", imem_addr, 64'h1000);
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = word_for(64'h1000);
    tick();
    imem_rvalid = 1'b0;
    tick();
    chk("rd_npop", mon_pc.size(), 1);
    if (mon_pc.size() > 0) begin
      chk("rd_outpc", mon_pc[0], 64'h1000);
      chk("rd_outins", mon_ins[0], word_for(64'h1000));
    end

    // Redirect coinciding with the response
    mon_pc.delete(); mon_ins.delete();
    imem_gnt = 1'b1;
    settle();
    chk("rr_addr", imem_addr, 64'h1004);
    tick();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h2000;
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD;
    settle();
    chk("rr_oval", out_valid, 0);
    tick();
    redirect_valid = 1'b0; imem_rvalid = 1'b0;
    settle();
    chk("rr_oval2", out_valid, 0);
    chk("rr_count", count, 0);
    chk("rr_idle", imem_req, 1);
    chk("rr_addr2", imem_addr, 64'h2000);
    chk("rr_npop", mon_pc.size(), 0);

    // Response to an empty queue with a ready consumer
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    settle();
`ifdef FETCHQ_BYPASS_EN
    chk("byp_oval", out_valid, 1);
    chk("byp_pc", out_pc, 64'h2000);
    chk("byp_ins", out_instruction, 32'h0050_0093);
`else
    chk("byp_oval", out_valid, 0);
`endif
    tick();
    imem_rvalid = 1'b0;
    settle();
`ifdef FETCHQ_BYPASS_EN
    chk("byp_oval2", out_valid, 0);
    chk("byp_count", count, 0);
`else
    chk("byp_oval2", out_valid, 1);
    chk("byp_pc", out_pc, 64'h2000);
    chk("byp_ins", out_instruction, 32'h0050_0093);
    chk("byp_count", count, 1);
`endif
    tick();
    chk("byp_count2", count, 0);

    // Reset with a request outstanding; the late response is ignored
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; reset = 1'b1;
    settle();
    chk("mr_req", imem_req, 0);
    chk("mr_oval", out_valid, 0);
    tick();
    reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0077;
    settle();
    chk("mr_addr", imem_addr, 64'h0);
    chk("mr_req2", imem_req, 1);
    tick();
    imem_rvalid = 1'b0;
    settle();
    chk("mr_count", count, 0);
    chk("mr_oval2", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
